regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
// Parametrised multi-port integer register file for the wider-issue core. Provides NUM_RD
// registered read ports and NUM_WR write ports with same-cycle write-to-read bypass. Includes a
// per-register busy scoreboard that the decode stage uses for RAW hazard detection.
// Sits between decode (read/issue side) and writeback (write/clear side).
// PARAMETERS
// NUM_REGS    32            architectural registers; x0 hardwired zero; power of 2
// NUM_RD      2             read ports (1..4)
// NUM_WR      1             write ports (1..2); higher index has priority
// DATA_WIDTH  `DATA_WIDTH   register width in bits
// AW          $clog2(NUM_REGS)  address width (equals `REG_ADDR_WIDTH at defaults)
// PORTS
// clk          in   1              clock; all state updates on the posedge
// rst_n        in   1              asynchronous active-low reset
// rd_en_i      in   NUM_RD         read port p captures a new value this edge
// rd_addr_i    in   NUM_RD x AW    read addresses
// rd_data_o    out  NUM_RD x DW    registered read data
// rd_busy_o    out  NUM_RD x 1     registered busy bit of the address captured on port p
// wr_en_i      in   NUM_WR         write enables (writeback)
// wr_addr_i    in   NUM_WR x AW    write addresses
// wr_data_i    in   NUM_WR x DW    write data
// sb_set_i     in   1              mark sb_set_addr_i busy (instruction issued)
// sb_set_addr_i in  AW             destination of the issued instruction
// flush_i      in   1              clear every busy bit (pipeline flush); register data is kept
// BEHAVIOUR
// - Reset: while rst_n=0, all regs, rd_data_o, rd_busy_o and busy bits are 0. Release is async-safe.
// - Write: on posedge, regs[wr_addr_i[w]] <= wr_data_i[w] if wr_en_i[w] and addr!=0.
//   Same address on two ports: the highest-index port wins. Address 0 is silently ignored.
// - Read: latency 1. On posedge with rd_en_i[p]=1, rd_data_o[p] <= value of rd_addr_i[p]
//   *after* this edge's writes (write-first bypass; highest-index matching write wins).
//   rd_en_i[p]=0: rd_data_o[p] and rd_busy_o[p] hold. Address 0 always yields 0.
// - Scoreboard: busy[NUM_REGS-1:1]; busy[0] is constant 0.
//   - Clear: busy[a] <= 0 for every wr_en_i[w] with addr a.
//   - Set: sb_set_i sets busy[sb_set_addr_i] (ignored for addr 0).
//     Set and clear of the same addr in the same cycle: set wins.
//   - flush_i: all busy <= 0; this overrides set and clear in that cycle. Writes still occur.
// - rd_busy_o[p]: on a read-enabled edge, captures the busy state *after* this edge's
//   set/clear/flush. Same-cycle writeback therefore reads as not busy, with data bypassed.
// - Outputs are pure flops; there is no combinational path from inputs to outputs.
// - Mid-operation reset: all state clears immediately. No partial write survives.
// STRUCTURE
// - Reuse `DATA_WIDTH/`REG_ADDR_WIDTH from common/defines.svh. Add regfile_pkg with
//   localparam ZERO_REG='0 and a function wr_resolve(), which returns the winning write for an
//   address; the data array and the bypass path both use it.
// - Sub-module regfile_scoreboard: busy vector, set/clear/flush priority, and NUM_RD lookup.
// - Data array: flop-based; generate loops over ports; no latches.
// TESTING
// 1 Reset: assert rst_n=0 mid-run after writing x5=0xDEAD -> rd_data_o=0, rd_busy_o=0; after release, read x5 -> 0.
// 2 Bypass: in the same cycle, wr x7=0x1234 and read port0 x7 -> rd_data_o[0]=0x1234 after 1 edge.
//   Port1 reading x7 one edge earlier -> old value.
// 3 Write conflict (NUM_WR=2): wr0 x3=0xAAAA and wr1 x3=0x5555 in the same cycle -> next read x3=0x5555.
// 4 x0: write x0=0xFFFF_FFFF with sb_set on x0 -> read x0 gives data 0, busy 0.
// 5 Scoreboard: set x9, read x9 -> busy=1; set x9 and write x9 in the same cycle -> busy=1;
//   write x9 alone -> busy=0; set x4,x6 then flush_i -> both read busy=0, with data unchanged.
// 6 Hold: write x2=0x11, read x2 with rd_en=1, then rd_en=0 while writing x2=0x22 -> rd_data_o stays 0x11.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The width macros fall back to the core defaults when no common defines are included.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package regfile_pkg;

  localparam int ZERO_REG = '0;
  localparam int MAX_WR   = 2;

  typedef struct packed {
    logic hit;
    logic idx;
  } wr_sel_t;

  // Picks the winning write port from a per-port address match vector; the higher port wins.
  function automatic wr_sel_t wr_resolve(input logic [MAX_WR-1:0] match);
    wr_sel_t sel;
    sel.hit = |match;
    sel.idx = match[1];
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with flush > set > clear priority.
// Lookups return the busy state as it will be after the current edge.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0] wr_addr_i,
  input  logic                     sb_set_i,
  input  logic [AW-1:0]            sb_set_addr_i,
  input  logic                     flush_i,
  input  logic [NUM_RD-1:0][AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        busy_o
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) busy_next[wr_addr_i[w]] = 1'b0;
    end
    if (sb_set_i && (sb_set_addr_i != AW'(ZERO_REG))) busy_next[sb_set_addr_i] = 1'b1;
    if (flush_i) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) busy_o[p] = busy_next[rd_addr_i[p]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered, write-first read ports
// and a busy scoreboard for RAW hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int AW         = $clog2(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD-1:0]                rd_en_i,
  input  logic [NUM_RD-1:0][AW-1:0]        rd_addr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]                rd_busy_o,
  input  logic [NUM_WR-1:0]                wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]        wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic                             sb_set_i,
  input  logic [AW-1:0]                    sb_set_addr_i,
  input  logic                             flush_i
);

  logic [DATA_WIDTH-1:0]             regs      [NUM_REGS];
  logic [DATA_WIDTH-1:0]             regs_next [NUM_REGS];
  logic [MAX_WR-1:0]                 match     [NUM_REGS];
  wr_sel_t                           sel       [NUM_REGS];
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_value;
  logic [NUM_RD-1:0]                 busy_look;

  // regs_next is the post-edge array; reads index it directly, which gives the write-first bypass.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      match[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        match[r][w] = wr_en_i[w] && (wr_addr_i[w] == AW'(r)) && (r != ZERO_REG);
      end
      sel[r] = wr_resolve(match[r]);
      regs_next[r] = regs[r];
      if (sel[r].hit) regs_next[r] = sel[r].idx ? wr_data_i[NUM_WR-1] : wr_data_i[0];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_value[p] = (rd_addr_i[p] == AW'(ZERO_REG)) ? '0 : regs_next[rd_addr_i[p]];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .AW      (AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .sb_set_i     (sb_set_i),
    .sb_set_addr_i(sb_set_addr_i),
    .flush_i      (flush_i),
    .rd_addr_i    (rd_addr_i),
    .busy_o       (busy_look)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      rd_data_o <= '0;
      rd_busy_o <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= regs_next[r];
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en_i[p]) begin
          rd_data_o[p] <= rd_value[p];
          rd_busy_o[p] <= busy_look[p];
        end
      end
    end
  end

endmodule
